// File: rtl/matrix_scan_ctrl_pkg.sv
// Shared constants and segment table for the dot-matrix / 7-segment scanner.
package matrix_scan_ctrl_pkg;

  localparam int SCAN_DIV_DEF  = 50000;
  localparam int BLANK_CYC_DEF = 100;

  localparam logic [7:0] ROW_OFF = 8'hFF;
  localparam logic [7:0] DS_OFF  = 8'hFF;

  // Segment order is {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] seg_lookup(input logic [3:0] hex);
    logic [6:0] seg;
    seg = 7'h00;
    unique case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex digit to 7-segment decoder.
module seg7_hex_dec
  import matrix_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = seg_lookup(hex);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Row/digit scan sequencer with a double-buffered frame store
// and an anti-ghosting blank interval at the start of every slot.
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV  = SCAN_DIV_DEF,
  parameter int BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_en,
  input  logic [2:0]  wr_row,
  input  logic [7:0]  wr_red,
  input  logic [7:0]  wr_green,
  input  logic        swap_req,
  output logic        swap_ack,
  input  logic [31:0] digits,
  output logic [7:0]  row,
  output logic [7:0]  led_R,
  output logic [7:0]  led_G,
  output logic [7:0]  DS,
  output logic [6:0]  num_,
  output logic        sof
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          front;
  logic          pend;

  logic [7:0] bank_r [2][8];
  logic [7:0] bank_g [2][8];

  logic       last;
  logic       drive;
  logic       go;
  logic [3:0] dig;
  logic [6:0] seg;
  logic [7:0] sel;

  assign last  = (cnt == CW'(SCAN_DIV - 1)) && (idx == 3'd7);
  assign drive = en && (cnt >= CW'(BLANK_CYC));
  // Disabling the display is treated as a frame boundary for swaps.
  assign go    = (pend || swap_req) && (!en || last);
  assign dig   = digits[{idx, 2'b00} +: 4];
  assign sel   = ~(8'd1 << idx);

  seg7_hex_dec u_dec (
    .hex(dig),
    .seg(seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      front    <= 1'b0;
      pend     <= 1'b0;
      swap_ack <= 1'b0;
      sof      <= 1'b0;
      row      <= ROW_OFF;
      DS       <= DS_OFF;
      led_R    <= '0;
      led_G    <= '0;
      num_     <= '0;
    end else begin
      if (!en) begin
        cnt <= '0;
        idx <= '0;
      end else if (cnt == CW'(SCAN_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      sof      <= en && (cnt == '0) && (idx == 3'd0);
      swap_ack <= go;
      pend     <= go ? 1'b0 : (pend | swap_req);
      if (go) front <= ~front;

      row   <= drive ? sel : ROW_OFF;
      DS    <= drive ? sel : DS_OFF;
      led_R <= drive ? bank_r[front][idx] : 8'h00;
      led_G <= drive ? bank_g[front][idx] : 8'h00;
      num_  <= drive ? seg : 7'h00;
    end
  end

  // Writes target the bank that is back before any swap on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          bank_r[b][r] <= '0;
          bank_g[b][r] <= '0;
        end
      end
    end else if (wr_en) begin
      bank_r[~front][wr_row] <= wr_red;
      bank_g[~front][wr_row] <= wr_green;
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Randomized scoreboard bench: a frame-level model predicts every
// registered output cycle, a monitor compares against the DUT.
module tb_matrix_scan_ctrl;

  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_row = '0;
  logic [7:0]  wr_red = '0;
  logic [7:0]  wr_green = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic [31:0] digits = 32'h7654_3210;
  logic [7:0]  row, led_R, led_G, DS;
  logic [6:0]  num_;
  logic        sof;

  matrix_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_en(wr_en), .wr_row(wr_row),
    .wr_red(wr_red), .wr_green(wr_green),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .digits(digits), .row(row),
    .led_R(led_R), .led_G(led_G),
    .DS(DS), .num_(num_), .sof(sof)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] ds;
    logic [6:0] num;
    logic       sof;
    logic       ack;
  } obs_t;

  obs_t q[$];
  int   nchk = 0;
  int   nfail = 0;
  int   nack = 0;

  logic [6:0] seg_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Model state: position within the 64-cycle frame, bank contents.
  int         m_t = 0;
  int         m_front = 0;
  bit         m_pend = 0;
  logic [7:0] m_r [2][8];
  logic [7:0] m_g [2][8];

  function automatic obs_t reset_obs();
    obs_t o;
    o = '{row: 8'hFF, r: 8'h00, g: 8'h00, ds: 8'hFF,
          num: 7'h00, sof: 1'b0, ack: 1'b0};
    return o;
  endfunction

  always @(posedge clk) begin
    obs_t e;
    int   pos;
    int   ix;
    bit   go;
    if (rst) begin
      m_t = 0; m_front = 0; m_pend = 0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++) begin
          m_r[b][r] = 8'h00;
          m_g[b][r] = 8'h00;
        end
      q.push_back(reset_obs());
    end else begin
      pos = m_t % SD;
      ix  = m_t / SD;
      e = reset_obs();
      if (en && pos >= BL) begin
        e.row = 8'hFF ^ (8'h01 << ix);
        e.ds  = e.row;
        e.r   = m_r[m_front][ix];
        e.g   = m_g[m_front][ix];
        e.num = seg_ref[(digits >> (4 * ix)) & 32'hF];
      end
      e.sof = en && m_t == 0;
      go = (m_pend || swap_req) && (!en || m_t == 8 * SD - 1);
      e.ack = go;
      if (wr_en) begin
        m_r[1 - m_front][wr_row] = wr_red;
        m_g[1 - m_front][wr_row] = wr_green;
      end
      if (go) m_front = 1 - m_front;
      m_pend = go ? 1'b0 : (m_pend || swap_req);
      m_t = en ? (m_t + 1) % (8 * SD) : 0;
      q.push_back(e);
    end
  end

  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      a = '{row: row, r: led_R, g: led_G, ds: DS,
            num: num_, sof: sof, ack: swap_ack};
      nchk++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL scoreboard_empty t=%0t got=%h want=entry", $time, a);
      end else begin
        e = q.pop_front();
        if (a.ack) nack++;
        if (a !== e) begin
          nfail++;
          $display("FAIL outputs t=%0t got row=%h R=%h G=%h DS=%h num=%h sof=%b ack=%b want row=%h R=%h G=%h DS=%h num=%h sof=%b ack=%b",
                   $time, a.row, a.r, a.g, a.ds, a.num, a.sof, a.ack,
                   e.row, e.r, e.g, e.ds, e.num, e.sof, e.ack);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_en = 1'b0;
      swap_req = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] r, input logic [7:0] rd,
                    input logic [7:0] gr);
    @(negedge clk);
    wr_en = 1'b1; wr_row = r; wr_red = rd; wr_green = gr;
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    idle(70);
    wr(3'd3, 8'hA5, 8'h0F);
    @(negedge clk);
    wr_en = 1'b0; swap_req = 1'b1;
    idle(140);
    wr(3'd3, 8'hFF, 8'hFF);
    idle(70);
    @(negedge clk);
    swap_req = 1'b1;
    repeat (199) @(negedge clk);
    swap_req = 1'b0;
    digits = 32'hFEDC_BA98;
    idle(70);
    // Write landing exactly on the swap edge.
    guard = 0;
    do begin
      @(negedge clk);
      wr_en = 1'b0; swap_req = 1'b0;
      guard++;
    end while (m_t != 8 * SD - 2 && guard < 200);
    if (guard >= 200) begin
      nchk++; nfail++;
      $display("FAIL align_timeout got=%0d want=<200", guard);
    end
    @(negedge clk);
    wr_en = 1'b1; wr_row = 3'd5; wr_red = 8'h3C; wr_green = 8'hC3;
    swap_req = 1'b1;
    idle(80);
    // Disable mid-slot with a swap pending.
    wr(3'd1, 8'h11, 8'h22);
    @(negedge clk);
    wr_en = 1'b0; swap_req = 1'b1;
    idle(12);
    en = 1'b0;
    idle(5);
    en = 1'b1;
    idle(30);
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 149) != 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_row   = 3'($urandom_range(0, 7));
      wr_red   = 8'($urandom);
      wr_green = 8'($urandom);
      swap_req = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) digits = $urandom;
    end
    idle(11);
    // Asynchronous reset in the middle of a DRIVE phase.
    guard = 0;
    while (m_t % SD != BL + 2 && guard < 100) begin
      idle(1);
      guard++;
    end
    #2 rst = 1'b1;
    #1;
    nchk++;
    if ({row, DS, led_R, led_G, num_, sof, swap_ack} !==
        {8'hFF, 8'hFF, 8'h00, 8'h00, 7'h00, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL async_reset got row=%h DS=%h R=%h G=%h num=%h want row=FF DS=FF R=00 G=00 num=00",
               row, DS, led_R, led_G, num_);
    end
    idle(2);
    rst = 1'b0;
    idle(20);
    nchk++;
    if (nack < 5) begin
      nfail++;
      $display("FAIL ack_activity got=%0d want>=5", nack);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
